// File: rtl/dmem_responder_if.sv
// Handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        memwrite;
  logic [1:0]  dsize;
  logic        loadext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        stall;

  modport master (output req, memwrite, dsize, loadext, addr, wdata,
                  input  rdata, ready, err, stall);
  modport slave  (input  req, memwrite, dsize, loadext, addr, wdata,
                  output rdata, ready, err, stall);
endinterface

// File: rtl/dmem_responder.sv
// Big-endian word RAM behind a req/ready handshake with WAIT wait states,
// byte/halfword lane select on loads and read-modify-write on partial stores.
module dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] WAIT_CNT  = 4'(WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  typedef struct packed {
    logic        memwrite;
    logic [1:0]  dsize;
    logic        loadext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dreq_t      req_q, req_in, acc;
  logic       latch, do_access;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.req) begin
        latch = 1'b1;
        cnt_d = WAIT_CNT;
        if (WAIT_CNT == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt_q <= 4'd1) begin
        do_access = 1'b1;
        cnt_d     = 4'd0;
        state_d   = ST_RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so it
  // must use the live request fields rather than the latched copy.
  assign req_in = {bus.memwrite, bus.dsize, bus.loadext, bus.addr, bus.wdata};
  assign acc    = (state_q == ST_IDLE) ? req_in : req_q;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              is_byte, is_half, is_word, misalign;

  assign word_idx = acc.addr[ADDR_W+1:2];
  assign lane     = acc.addr[1:0];
  assign is_byte  = (acc.dsize == 2'b10);
  assign is_half  = (acc.dsize == 2'b01);
  assign is_word  = !is_byte && !is_half;
  assign misalign = (is_half & acc.addr[0]) | (is_word & (|acc.addr[1:0]));

  logic [31:0]                 mem [2**ADDR_W];
  logic [NUM_LANES-1:0][7:0]   old_w, new_w;
  logic [NUM_LANES-1:0]        be;
  logic                        ram_we;

  assign old_w = mem[word_idx];

  // Packed element g holds big-endian byte lane NUM_LANES-1-g.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] BE_LANE = 2'(NUM_LANES - 1 - g);
    assign be[g]    = is_word | (is_half & (acc.addr[1] == BE_LANE[1]))
                    | (is_byte & (lane == BE_LANE));
    assign new_w[g] = !be[g]  ? old_w[g] :
                      is_byte ? acc.wdata[7:0] :
                      is_half ? (((g % 2) == 1) ? acc.wdata[15:8] : acc.wdata[7:0]) :
                                acc.wdata[8*g +: 8];
  end

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_val;

  assign sel_b = old_w[~lane];
  assign sel_h = acc.addr[1] ? old_w[1:0] : old_w[3:2];

  always_comb begin
    load_val = old_w;
    if (is_byte)      load_val = {{24{acc.loadext & sel_b[7]}}, sel_b};
    else if (is_half) load_val = {{16{acc.loadext & sel_h[15]}}, sel_h};
  end

  // Qualified by reset so a zero-wait request held during reset cannot write.
  assign ram_we = do_access & acc.memwrite & ~misalign & reset;

  always_ff @(posedge clock) begin
    if (ram_we) mem[word_idx] <= new_w;
  end

  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) req_q <= req_in;
      if (do_access) begin
        err_q   <= misalign;
        rdata_q <= (misalign | acc.memwrite) ? 32'd0 : load_val;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.ready = (state_q == ST_RESP);
  assign bus.stall = bus.req & ~bus.ready;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: vector table on a WAIT=2 responder, plus reset-abort (WAIT=3)
// and back-to-back aliasing (WAIT=0) sequences.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst2 = 1'b0, rst3 = 1'b0, rst0 = 1'b0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_responder_if b2 ();
  dmem_responder_if b3 ();
  dmem_responder_if b0 ();

  dmem_responder #(.ADDR_W(10), .WAIT(2)) u2 (.clock(clk), .reset(rst2), .bus(b2));
  dmem_responder #(.ADDR_W(10), .WAIT(3)) u3 (.clock(clk), .reset(rst3), .bus(b3));
  dmem_responder #(.ADDR_W(10), .WAIT(0)) u0 (.clock(clk), .reset(rst0), .bus(b0));

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One WAIT=2 transaction; req is held until ready, then dropped.
  task automatic txn2(input vec_t v, input int idx);
    int  c;
    bit  stall_ok;
    @(posedge clk); #1;
    b2.req = 1'b1; b2.memwrite = v.we; b2.dsize = v.sz; b2.loadext = v.ext;
    b2.addr = v.addr; b2.wdata = v.wd;
    stall_ok = 1'b1;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b2.ready) break;
      if (!b2.stall) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d latency", idx), c, 3);
    chk($sformatf("v%0d stall_busy", idx), {31'd0, stall_ok}, 1);
    chk($sformatf("v%0d stall_at_ready", idx), {31'd0, b2.stall}, 0);
    chk($sformatf("v%0d rdata", idx), b2.rdata, v.exp_rd);
    chk($sformatf("v%0d err", idx), {31'd0, b2.err}, {31'd0, v.exp_err});
    @(posedge clk); #1;
    b2.req = 1'b0; b2.wdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk($sformatf("v%0d ready_drop", idx), {31'd0, b2.ready}, 0);
    chk($sformatf("v%0d rdata_hold", idx), b2.rdata, v.exp_rd);
  endtask

  task automatic wait_rdy3(output int c);
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b3.ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    b3.req = 1'b0;
  endtask

  initial begin
    int c;
    bit saw_ready;

    //         we    sz     ext   addr          wdata          exp_rd         err
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 32'h00000040, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h00000040, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 1'b1, 32'h00000041, 32'h0,        32'hFFFFFFAD, 1'b0};
    tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h00000043, 32'h0,        32'h000000EF, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 1'b1, 32'h00000042, 32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h00000040, 32'hAAAAAA12, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 32'h00000040, 32'h0,        32'h12ADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h00000042, 32'hBBBB3456, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 1'b0, 32'h00000040, 32'h0,        32'h12AD3456, 1'b0};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h00000041, 32'h0,        32'h00000000, 1'b1};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 32'h00000042, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 32'h00000040, 32'h0,        32'h12AD3456, 1'b0};
    tbl[12] = '{1'b0, 2'b10, 1'b0, 32'h00000040, 32'h0,        32'h00000012, 1'b0};
    tbl[13] = '{1'b0, 2'b01, 1'b1, 32'h00000040, 32'h0,        32'h000012AD, 1'b0};
    tbl[14] = '{1'b0, 2'b10, 1'b1, 32'h00000042, 32'h0,        32'h00000034, 1'b0};
    tbl[15] = '{1'b0, 2'b11, 1'b0, 32'h00000040, 32'h0,        32'h12AD3456, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 1'b0, 32'h00000043, 32'h0,        32'h00000000, 1'b1};
    tbl[17] = '{1'b0, 2'b10, 1'b1, 32'h00000041, 32'h0,        32'hFFFFFFAD, 1'b0};

    b2.req = 1'b0; b2.memwrite = 1'b0; b2.dsize = 2'b00; b2.loadext = 1'b0; b2.addr = '0; b2.wdata = '0;
    b3.req = 1'b0; b3.memwrite = 1'b0; b3.dsize = 2'b00; b3.loadext = 1'b0; b3.addr = '0; b3.wdata = '0;
    b0.req = 1'b0; b0.memwrite = 1'b0; b0.dsize = 2'b00; b0.loadext = 1'b0; b0.addr = '0; b0.wdata = '0;

    // Reset state, stall following req while held in reset
    #2;
    chk("rst ready", {31'd0, b2.ready}, 0);
    chk("rst err", {31'd0, b2.err}, 0);
    chk("rst rdata", b2.rdata, 0);
    b2.req = 1'b1; #1;
    chk("rst stall_follows_req", {31'd0, b2.stall}, 1);
    b2.req = 1'b0; #1;
    chk("rst stall_low", {31'd0, b2.stall}, 0);
    @(posedge clk); #1;
    rst2 = 1'b1; rst3 = 1'b1; rst0 = 1'b1;

    for (int i = 0; i < NV; i++) txn2(tbl[i], i);

    // WAIT=3: seed 0x80, read it back, then abort a store with reset
    @(posedge clk); #1;
    b3.req = 1'b1; b3.memwrite = 1'b1; b3.dsize = 2'b00; b3.addr = 32'h80; b3.wdata = 32'h01020304;
    wait_rdy3(c);
    chk("w3 store latency", c, 4);
    @(posedge clk); #1;
    b3.req = 1'b1; b3.memwrite = 1'b0; b3.addr = 32'h80;
    wait_rdy3(c);
    chk("w3 load latency", c, 4);
    chk("w3 seed rdata", b3.rdata, 32'h01020304);
    @(posedge clk); #1;
    b3.req = 1'b1; b3.memwrite = 1'b1; b3.addr = 32'h80; b3.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    b3.req = 1'b0;
    @(negedge clk);
    chk("w3 abort ready", {31'd0, b3.ready}, 0);
    chk("w3 abort rdata", b3.rdata, 0);
    chk("w3 abort err", {31'd0, b3.err}, 0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    saw_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b3.ready) saw_ready = 1'b1;
    end
    chk("w3 no_ready_after_abort", {31'd0, saw_ready}, 0);
    @(posedge clk); #1;
    b3.req = 1'b1; b3.memwrite = 1'b0; b3.addr = 32'h80;
    wait_rdy3(c);
    chk("w3 post_abort rdata", b3.rdata, 32'h01020304);

    // WAIT=0: back-to-back store then aliased load with req held high
    @(posedge clk); #1;
    b0.req = 1'b1; b0.memwrite = 1'b1; b0.dsize = 2'b00; b0.loadext = 1'b0;
    b0.addr = 32'h0; b0.wdata = 32'h11111111;
    @(negedge clk);
    chk("w0 c0 ready", {31'd0, b0.ready}, 0);
    chk("w0 c0 stall", {31'd0, b0.stall}, 1);
    @(posedge clk); #1;
    b0.memwrite = 1'b0; b0.addr = 32'h1000; b0.wdata = 32'h0;
    @(negedge clk);
    chk("w0 c1 ready", {31'd0, b0.ready}, 1);
    chk("w0 c1 stall", {31'd0, b0.stall}, 0);
    chk("w0 c1 rdata", b0.rdata, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0 c2 ready", {31'd0, b0.ready}, 0);
    chk("w0 c2 stall", {31'd0, b0.stall}, 1);
    @(posedge clk); #1;
    b0.req = 1'b0;
    @(negedge clk);
    chk("w0 c3 ready", {31'd0, b0.ready}, 1);
    chk("w0 c3 rdata", b0.rdata, 32'h11111111);
    chk("w0 c3 err", {31'd0, b0.err}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0 c4 ready", {31'd0, b0.ready}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
